// File: rtl/sram_arb_pkg.sv
// Shared constants and types for the two-master SRAM port arbiter.
// Provides requester count, requester index type and default widths.
package sram_arb_pkg;

    localparam int SRAM_ARB_NREQ = 2;
    localparam int SRAM_ARB_AW   = 8;
    localparam int SRAM_ARB_DW   = 8;

    typedef logic [$clog2(SRAM_ARB_NREQ)-1:0] req_idx_t;

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational grant picker: request vector (+ last pointer) -> one-hot grant.
// Ports: req[1:0], last (round-robin build only), gnt[1:0].
// Build option: SRAM_ARB_RR_EN selects round-robin, otherwise master 0 wins.
import sram_arb_pkg::*;

module sram_arb_pick (
    input  logic [SRAM_ARB_NREQ-1:0] req,
`ifdef SRAM_ARB_RR_EN
    input  req_idx_t                 last,
`endif
    output logic [SRAM_ARB_NREQ-1:0] gnt
);

    always_comb begin
        gnt = '0;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
`ifdef SRAM_ARB_RR_EN
            // On contention the master that did not win last time goes.
            2'b11:   gnt = (last == req_idx_t'(1)) ? 2'b01 : 2'b10;
`else
            2'b11:   gnt = 2'b01;
`endif
            default: gnt = '0;
        endcase
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-master arbiter/sequencer in front of a single-port registered-read SRAM.
// Ports: clk, rst, req/we/addr/wdata per master, gnt0/1, rvalid0/1, rdata,
//        ram_write/ram_addr/ram_wdata to the SRAM, ram_rdata from it.
// Build option: SRAM_ARB_RR_EN enables round-robin (default: fixed priority).
import sram_arb_pkg::*;

module sram_port_arbiter #(
    parameter int ADDR_WIDTH = SRAM_ARB_AW,
    parameter int DATA_WIDTH = SRAM_ARB_DW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ram_write,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    logic [SRAM_ARB_NREQ-1:0] req_v;
    logic [SRAM_ARB_NREQ-1:0] pick;
    logic [SRAM_ARB_NREQ-1:0] gnt_v;
    logic                     gnt_any;
    req_idx_t                 sel;
    logic                     sel_we;
    logic [ADDR_WIDTH-1:0]    sel_addr;
    logic [DATA_WIDTH-1:0]    sel_wdata;
    logic [ADDR_WIDTH-1:0]    addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic                     rd_pend;
    req_idx_t                 rd_id;

    assign req_v = {req1, req0};

`ifdef SRAM_ARB_RR_EN
    req_idx_t last;

    sram_arb_pick u_pick (
        .req  (req_v),
        .last (last),
        .gnt  (pick)
    );

    // Reset to master 1 so master 0 wins the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= req_idx_t'(1);
        end else if (gnt_any) begin
            last <= sel;
        end
    end
`else
    sram_arb_pick u_pick (
        .req (req_v),
        .gnt (pick)
    );
`endif

    // No grant may be issued while reset is held.
    assign gnt_v   = pick & {SRAM_ARB_NREQ{~rst}};
    assign gnt0    = gnt_v[0];
    assign gnt1    = gnt_v[1];
    assign gnt_any = |gnt_v;
    assign sel     = req_idx_t'(gnt_v[1]);

    assign sel_we    = sel[0] ? we1    : we0;
    assign sel_addr  = sel[0] ? addr1  : addr0;
    assign sel_wdata = sel[0] ? wdata1 : wdata0;

    // The SRAM samples on the granting edge itself; between grants the
    // shadow copies keep the address and data lines quiet.
    assign ram_write = gnt_any & sel_we;
    assign ram_addr  = gnt_any ? sel_addr  : addr_q;
    assign ram_wdata = gnt_any ? sel_wdata : wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rd_pend <= 1'b0;
            rd_id   <= '0;
        end else begin
            rd_pend <= gnt_any & ~sel_we;
            if (gnt_any) begin
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
                rd_id   <= sel;
            end
        end
    end

    assign rvalid0 = rd_pend & (rd_id == req_idx_t'(0));
    assign rvalid1 = rd_pend & (rd_id == req_idx_t'(1));
    assign rdata   = ram_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed self-checking bench for sram_port_arbiter with a behavioural SRAM.
// Unwritten SRAM locations read back as the bitwise inverse of their address.
module tb_sram_port_arbiter;

`ifdef SRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, we0, we1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0] rdata;
    logic       ram_write;
    logic [7:0] ram_addr, ram_wdata;
    logic [7:0] ram_rdata = 8'h00;

    int n_chk  = 0;
    int n_fail = 0;

    bit [7:0]   mem [256];
    bit [255:0] written;

    always #5 clk = ~clk;

    // Single-port SRAM: registered read, data_out holds on write cycles.
    always @(posedge clk) begin
        if (ram_write) begin
            mem[ram_addr]     <= ram_wdata;
            written[ram_addr] <= 1'b1;
        end else begin
            ram_rdata <= written[ram_addr] ? mem[ram_addr] : ~ram_addr;
        end
    end

    sram_port_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata     (rdata),
        .ram_write (ram_write),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        bit g0;
        rst = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        we0 = 1'b0;  we1 = 1'b0;
        addr0 = 8'h01; addr1 = 8'h02;
        wdata0 = 8'h00; wdata1 = 8'h00;

        // Reset state with both requests raised
        @(negedge clk); #1;
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_ram_write", ram_write, 0);
        chk("rst_ram_addr", ram_addr, 8'h00);
        chk("rst_ram_wdata", ram_wdata, 8'h00);
        @(posedge clk); #1;
        chk("rst_rvalid0", rvalid0, 0);
        chk("rst_rvalid1", rvalid1, 0);

        @(negedge clk);
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;

        // Contention: both read continuously for 5 cycles
        for (int i = 0; i < 5; i++) begin
            g0 = RR ? (i % 2 == 0) : 1'b1;
            @(negedge clk);
            req0 = 1'b1; we0 = 1'b0; addr0 = 8'h01;
            req1 = 1'b1; we1 = 1'b0; addr1 = 8'h02;
            #1;
            chk($sformatf("cont%0d_gnt0", i), gnt0, g0);
            chk($sformatf("cont%0d_gnt1", i), gnt1, !g0);
            chk($sformatf("cont%0d_addr", i), ram_addr,
                g0 ? 8'h01 : 8'h02);
            @(posedge clk); #1;
            chk($sformatf("cont%0d_rv0", i), rvalid0, g0);
            chk($sformatf("cont%0d_rv1", i), rvalid1, !g0);
            chk($sformatf("cont%0d_rdata", i), rdata, g0 ? 8'hFE : 8'hFD);
        end

        // Master 0 writes A5 to 0x10 then reads it back
        @(negedge clk);
        req1 = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h10; wdata0 = 8'hA5;
        #1;
        chk("wr_gnt0", gnt0, 1);
        chk("wr_gnt1", gnt1, 0);
        chk("wr_ram_write", ram_write, 1);
        chk("wr_ram_addr", ram_addr, 8'h10);
        chk("wr_ram_wdata", ram_wdata, 8'hA5);
        @(posedge clk); #1;
        chk("wr_rvalid0", rvalid0, 0);
        @(negedge clk);
        we0 = 1'b0;
        #1;
        chk("rd_gnt0", gnt0, 1);
        chk("rd_ram_write", ram_write, 0);
        @(posedge clk); #1;
        chk("rd_rvalid0", rvalid0, 1);
        chk("rd_rvalid1", rvalid1, 0);
        chk("rd_rdata", rdata, 8'hA5);

        // Master 1 reads 0x7F, then everything goes idle for 3 cycles
        @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h7F;
        #1;
        chk("r7f_gnt1", gnt1, 1);
        chk("r7f_gnt0", gnt0, 0);
        @(posedge clk); #1;
        chk("r7f_rvalid1", rvalid1, 1);
        chk("r7f_rdata", rdata, 8'h80);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req1 = 1'b0; addr1 = 8'h33;
            #1;
            chk($sformatf("idle%0d_gnt", i), {gnt1, gnt0}, 2'b00);
            chk($sformatf("idle%0d_write", i), ram_write, 0);
            chk($sformatf("idle%0d_addr", i), ram_addr, 8'h7F);
            @(posedge clk); #1;
            chk($sformatf("idle%0d_rv", i), {rvalid1, rvalid0}, 2'b00);
        end

        // Mixed: master 0 reads 0x20 while master 1 writes 3C to 0x20
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h20;
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h20; wdata1 = 8'h3C;
        #1;
        chk("mix1_gnt0", gnt0, 1);
        chk("mix1_gnt1", gnt1, 0);
        chk("mix1_write", ram_write, 0);
        @(posedge clk); #1;
        chk("mix1_rvalid0", rvalid0, 1);
        chk("mix1_rdata", rdata, 8'hDF);
        @(negedge clk);
        req0 = 1'b0;
        #1;
        chk("mix2_gnt1", gnt1, 1);
        chk("mix2_write", ram_write, 1);
        chk("mix2_addr", ram_addr, 8'h20);
        chk("mix2_wdata", ram_wdata, 8'h3C);
        @(posedge clk); #1;
        chk("mix2_rv", {rvalid1, rvalid0}, 2'b00);
        chk("mix2_rdata_hold", rdata, 8'hDF);
        @(negedge clk);
        req1 = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h20;
        #1;
        chk("mix3_gnt0", gnt0, 1);
        @(posedge clk); #1;
        chk("mix3_rvalid0", rvalid0, 1);
        chk("mix3_rdata", rdata, 8'h3C);

        // Reset asserted with a read pending
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h01;
        #1;
        chk("rpend_gnt0", gnt0, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rmid_rv", {rvalid1, rvalid0}, 2'b00);
        chk("rmid_write", ram_write, 0);
        chk("rmid_gnt0", gnt0, 0);
        chk("rmid_addr", ram_addr, 8'h00);

        // After release the first contention goes to master 0
        @(negedge clk);
        rst = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h01;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h02;
        #1;
        chk("post_gnt0", gnt0, 1);
        chk("post_gnt1", gnt1, 0);
        @(posedge clk); #1;
        chk("post_rvalid0", rvalid0, 1);
        chk("post_rdata", rdata, 8'hFE);
        @(negedge clk); #1;
        chk("post2_gnt0", gnt0, !RR);
        chk("post2_gnt1", gnt1, RR);
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
